du_inst_loader: RTL and testbench
=================================

// Module: du_inst_loader
// PURPOSE
//  Debug-unit controller that sequences program loading into instruction memory.
//  - Consumes UART RX bytes: one count byte N, then 4*N instruction bytes, LSB first.
//  - Packs each 4 bytes into a 32-bit word and issues one write per word at byte
//    address 0, 4, 8, ...
//  - Reports completion, error and instruction count to the debug-unit mode FSM.
//    That FSM then accepts the step/continue mode byte.
// PARAMETERS
//  NB_DATA      32   instruction word width, also the address width
//  N_BITS_DATA  8    UART byte width
//  N_BYTES      4    bytes per instruction; fixed by packing, not overridable
//  MAX_INST     255  largest accepted instruction count N
// PORTS
//  clock_i        in   1            system clock
//  reset_i        in   1            asynchronous reset, active-high
//  load_en_i      in   1            load window open; low aborts and returns to IDLE
//  rx_done_i      in   1            one-cycle strobe: rx_data_i valid
//  rx_data_i      in   N_BITS_DATA  received byte
//  en_write_o     out  1            one-cycle instruction-memory write strobe
//  address_o      out  NB_DATA      byte address of the current write
//  inst_load_o    out  NB_DATA      assembled instruction word
//  busy_o         out  1            high in GET_COUNT, RECV_INST, RECV_CSUM
//  load_done_o    out  1            one-cycle pulse, load completed without error
//  inst_count_o   out  N_BITS_DATA  N latched from the count byte
//  error_o        out  1            sticky error flag; cleared on the next GET_COUNT entry
// BEHAVIOUR
//  Reset: every output is 0; state=IDLE; byte counter=0; word counter=0.
//  All outputs are registered. Bytes are only sampled on rx_done_i=1.
//  States:
//   IDLE       -> GET_COUNT when load_en_i=1. Clears error_o, address_o, counters.
//   GET_COUNT  byte = N. Latch it into inst_count_o.
//              - N==0: DONE, with load_done_o pulsed and no writes.
//              - N>MAX_INST: error_o=1, go to DONE.
//              - Otherwise: RECV_INST.
//   RECV_INST  byte k (0..3) goes into word bits [8k+7:8k]. On k==3:
//              - next cycle: en_write_o=1, inst_load_o=word, address_o=4*word_idx.
//              - word_idx increments.
//              - last word: go to RECV_CSUM if enabled, else DONE with load_done_o pulsed.
//   RECV_CSUM  (only with the macro) see CONFIGURATION.
//   DONE       hold until load_en_i=0, then IDLE. Extra bytes are ignored.
//  - A byte arriving in the same cycle as en_write_o is accepted as byte 0 of the next
//    word. There are no bubble cycles, so back-to-back strobes are legal.
//  - load_en_i=0 in any state aborts to IDLE on the next edge. A partial word is dropped
//    and no write is issued. error_o is set if the abort happens in RECV_INST or
//    RECV_CSUM.
//  - address_o holds its last value between writes. The word counter is N_BITS_DATA
//    wide and never wraps, because N<=MAX_INST.
//  - reset_i asserted mid-load forces IDLE immediately. Any pending en_write_o is killed.
// CONFIGURATION
//  DU_LOADER_CHECKSUM_EN defined:
//   - One extra byte follows the last instruction.
//   - It must equal the XOR of N and all 4*N instruction bytes.
//   - Match: load_done_o is pulsed. Mismatch: error_o=1 and there is no done pulse.
//   - Writes already issued are not retracted.
//  DU_LOADER_CHECKSUM_EN undefined:
//   - RECV_CSUM and the XOR accumulator are not built.
//   - DONE follows the last write directly.
// STRUCTURE
//  Shared package du_pkg holds:
//   - state encodings
//   - N_BYTES=4, BYTE_PC=4
//   - mode codes MODE_STEP=8'h0F and MODE_CONT=8'hF0, consumed by the debug-unit FSM
//  Sub-module du_byte_packer: 2-bit byte counter plus shift-in register. Ports:
//   - clear_i, byte_valid_i, byte_i
//   - word_o, word_valid_o (one cycle)
//  The loader FSM, address/word counters and checksum stay in du_inst_loader.
// TESTING
//  1. N=8, bytes of 8 words, e.g. 0x20010005 sent as 05 00 01 20
//     -> 8 en_write_o pulses, address 0x00..0x1C, words exact, load_done_o once.
//  2. Count byte 0x00 -> load_done_o 1 cycle later, zero writes, inst_count_o=0.
//  3. N=2, load_en_i dropped after 5 bytes
//     -> exactly 1 write (addr 0), error_o=1, state IDLE, no load_done_o.
//  4. rx_done_i every cycle (N=3, 12 bytes back-to-back)
//     -> 3 writes 4 cycles apart, none lost.
//  5. reset_i pulsed after byte 3 of word 0 -> no en_write_o, all outputs 0.
//  6. Checksum macro on, N=1, word 0xAABBCCDD:
//     - csum byte 0x01^0xDD^0xCC^0xBB^0xAA=0x01 -> load_done_o.
//     - csum byte 0x02 -> error_o=1.

Source files
------------

// File: rtl/du_pkg.sv
// Shared debug-unit definitions: loader state encoding, packing constants and
// the step/continue mode codes consumed by the debug-unit mode FSM.
// The loader's optional checksum stage is enabled by DU_LOADER_CHECKSUM_EN.
package du_pkg;

  // Bytes per instruction word and byte-address increment per word.
  localparam int N_BYTES = 4;
  localparam int BYTE_PC = 4;

  // Mode bytes accepted by the debug-unit FSM after a load completes.
  localparam logic [7:0] MODE_STEP = 8'h0F;
  localparam logic [7:0] MODE_CONT = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_COUNT = 3'd1,
    ST_RECV_INST = 3'd2,
    ST_RECV_CSUM = 3'd3,
    ST_DONE      = 3'd4
  } load_state_t;

endpackage

// File: rtl/du_byte_packer.sv
// Byte-to-word packer: a 2-bit byte counter plus a shift-in register holding the
// first three bytes of a word (LSB first). On the fourth byte it presents the
// complete word together with a one-cycle word_valid_o, in the same cycle as that
// byte, so the loader can register the write on the very next edge.
module du_byte_packer
  import du_pkg::*;
#(
  parameter int N_BITS_DATA = 8
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic                             clear_i,
  input  logic                             byte_valid_i,
  input  logic [N_BITS_DATA-1:0]           byte_i,
  output logic [N_BYTES*N_BITS_DATA-1:0]   word_o,
  output logic                             word_valid_o
);

  localparam int SHIFT_W = (N_BYTES - 1) * N_BITS_DATA;

  logic [1:0]         cnt_q, cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;

  // Next byte count and shift contents; clear drops any partial word.
  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (byte_valid_i) begin
      // Counter wraps to 0 after the fourth byte, ready for the next word.
      cnt_d   = cnt_q + 2'd1;
      shift_d = {byte_i, shift_q[SHIFT_W-1:N_BITS_DATA]};
    end
  end

  // Counter and shift register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign word_o       = {byte_i, shift_q};
  assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'(N_BYTES - 1));

endmodule

// File: rtl/du_inst_loader.sv
// Debug-unit instruction loader: receives a count byte N then 4*N instruction
// bytes from the UART, writing one 32-bit word per four bytes at byte addresses
// 0, 4, 8, ... All outputs are registered.
// Define DU_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module du_inst_loader
  import du_pkg::*;
#(
  parameter int NB_DATA     = 32,
  parameter int N_BITS_DATA = 8,
  parameter int MAX_INST    = 255
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   load_en_i,
  input  logic                   rx_done_i,
  input  logic [N_BITS_DATA-1:0] rx_data_i,
  output logic                   en_write_o,
  output logic [NB_DATA-1:0]     address_o,
  output logic [NB_DATA-1:0]     inst_load_o,
  output logic                   busy_o,
  output logic                   load_done_o,
  output logic [N_BITS_DATA-1:0] inst_count_o,
  output logic                   error_o
);

  load_state_t              state_q, state_d;
  logic [N_BITS_DATA-1:0]   word_idx_q, word_idx_d;
  logic [N_BITS_DATA-1:0]   inst_count_q, inst_count_d;
  logic [NB_DATA-1:0]       address_q, address_d;
  logic [NB_DATA-1:0]       inst_load_q, inst_load_d;
  logic                     en_write_q, en_write_d;
  logic                     busy_q, busy_d;
  logic                     load_done_q, load_done_d;
  logic                     error_q, error_d;
  logic                     last_word;

  logic                             packer_clear;
  logic                             packer_valid;
  logic [N_BYTES*N_BITS_DATA-1:0]   packed_word;
  logic                             packed_valid;

`ifdef DU_LOADER_CHECKSUM_EN
  logic [N_BITS_DATA-1:0]   csum_q, csum_d;
`endif

  // Only instruction bytes reach the packer; any other state or an abort empties it.
  assign packer_valid = rx_done_i && load_en_i && (state_q == ST_RECV_INST);
  assign packer_clear = !load_en_i || (state_q != ST_RECV_INST);

  du_byte_packer #(
    .N_BITS_DATA (N_BITS_DATA)
  ) u_packer (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .clear_i      (packer_clear),
    .byte_valid_i (packer_valid),
    .byte_i       (rx_data_i),
    .word_o       (packed_word),
    .word_valid_o (packed_valid)
  );

  // Next-state, counters and registered-output values of the loader FSM.
  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    inst_count_d = inst_count_q;
    address_d    = address_q;
    inst_load_d  = inst_load_q;
    en_write_d   = 1'b0;
    load_done_d  = 1'b0;
    error_d      = error_q;
    last_word    = (word_idx_q == inst_count_q - N_BITS_DATA'(1));
`ifdef DU_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    if (!load_en_i) begin
      // Abort: partial word is dropped by the packer; mid-transfer aborts are errors.
      state_d = ST_IDLE;
      if (state_q == ST_RECV_INST || state_q == ST_RECV_CSUM) begin
        error_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_GET_COUNT;
          error_d    = 1'b0;
          address_d  = '0;
          word_idx_d = '0;
`ifdef DU_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end

        ST_GET_COUNT: begin
          if (rx_done_i) begin
            inst_count_d = rx_data_i;
`ifdef DU_LOADER_CHECKSUM_EN
            csum_d       = rx_data_i;
`endif
            if (rx_data_i == '0) begin
              state_d     = ST_DONE;
              load_done_d = 1'b1;
            end else if (int'(rx_data_i) > MAX_INST) begin
              state_d = ST_DONE;
              error_d = 1'b1;
            end else begin
              state_d = ST_RECV_INST;
            end
          end
        end

        ST_RECV_INST: begin
`ifdef DU_LOADER_CHECKSUM_EN
          if (rx_done_i) begin
            csum_d = csum_q ^ rx_data_i;
          end
`endif
          if (packed_valid) begin
            en_write_d  = 1'b1;
            inst_load_d = NB_DATA'(packed_word);
            address_d   = NB_DATA'(word_idx_q) * NB_DATA'(BYTE_PC);
            word_idx_d  = word_idx_q + N_BITS_DATA'(1);
            if (last_word) begin
`ifdef DU_LOADER_CHECKSUM_EN
              state_d     = ST_RECV_CSUM;
`else
              state_d     = ST_DONE;
              load_done_d = 1'b1;
`endif
            end
          end
        end

`ifdef DU_LOADER_CHECKSUM_EN
        ST_RECV_CSUM: begin
          if (rx_done_i) begin
            state_d = ST_DONE;
            if (rx_data_i == csum_q) begin
              load_done_d = 1'b1;
            end else begin
              error_d = 1'b1;
            end
          end
        end
`endif

        ST_DONE: begin
          state_d = ST_DONE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_GET_COUNT) || (state_d == ST_RECV_INST) ||
             (state_d == ST_RECV_CSUM);
  end

  // State and output registers; reset also kills any pending write strobe.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      word_idx_q   <= '0;
      inst_count_q <= '0;
      address_q    <= '0;
      inst_load_q  <= '0;
      en_write_q   <= 1'b0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      inst_count_q <= inst_count_d;
      address_q    <= address_d;
      inst_load_q  <= inst_load_d;
      en_write_q   <= en_write_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
      error_q      <= error_d;
    end
  end

`ifdef DU_LOADER_CHECKSUM_EN
  // Running XOR of the count byte and all instruction bytes.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign en_write_o   = en_write_q;
  assign address_o    = address_q;
  assign inst_load_o  = inst_load_q;
  assign busy_o       = busy_q;
  assign load_done_o  = load_done_q;
  assign inst_count_o = inst_count_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_du_inst_loader.sv
// Directed bench for du_inst_loader. Inputs change on the falling edge; outputs
// are observed on the falling edge. A monitor logs every write and done pulse.
// Define DU_LOADER_CHECKSUM_EN for both bench and RTL to exercise the checksum.
module tb_du_inst_loader;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        en_write;
  logic [31:0] address;
  logic [31:0] inst_load;
  logic        busy;
  logic        load_done;
  logic [7:0]  inst_count;
  logic        error;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          done_cnt = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [7:0]  csum;

  logic [31:0] prog1 [8] = '{32'h20010005, 32'h20020006, 32'h20030007, 32'h00221820,
                             32'hAC030000, 32'h8C040000, 32'h10000002, 32'hFFFFFFFF};
  logic [31:0] prog4 [3] = '{32'h11223344, 32'h55667788, 32'h99AABBCC};

  du_inst_loader dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .load_en_i    (load_en),
    .rx_done_i    (rx_done),
    .rx_data_i    (rx_data),
    .en_write_o   (en_write),
    .address_o    (address),
    .inst_load_o  (inst_load),
    .busy_o       (busy),
    .load_done_o  (load_done),
    .inst_count_o (inst_count),
    .error_o      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (en_write) begin
      wr_addr.push_back(address);
      wr_data.push_back(inst_load);
      wr_cyc.push_back(cyc);
    end
    if (load_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt = 0;
  endtask

  // One strobe per call; consecutive calls give back-to-back strobes.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    csum    = csum ^ b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic open_window();
    load_en = 1'b1;
    @(negedge clk);
    csum = 8'h00;
  endtask

  task automatic close_window();
    load_en = 1'b0;
    idle(2);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; rx_done = 1'b0; rx_data = 8'h00; csum = 8'h00;
    idle(2);

    // Reset state
    check("rst_en_write",   {31'b0, en_write}, 32'h0);
    check("rst_address",    address, 32'h0);
    check("rst_inst_load",  inst_load, 32'h0);
    check("rst_busy",       {31'b0, busy}, 32'h0);
    check("rst_load_done",  {31'b0, load_done}, 32'h0);
    check("rst_inst_count", {24'b0, inst_count}, 32'h0);
    check("rst_error",      {31'b0, error}, 32'h0);
    rst = 1'b0;
    idle(1);

    // 1. Eight words with an idle cycle between words
    clear_log();
    open_window();
    check("t1_busy_getcount", {31'b0, busy}, 32'h1);
    send_byte(8'd8);
    check("t1_inst_count", {24'b0, inst_count}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      send_word(prog1[i]);
      idle(1);
    end
`ifdef DU_LOADER_CHECKSUM_EN
    send_byte(csum);
`endif
    idle(2);
    check("t1_num_writes", wr_addr.size(), 32'd8);
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      check($sformatf("t1_addr%0d", i), wr_addr[i], 32'(i * 4));
      check($sformatf("t1_data%0d", i), wr_data[i], prog1[i]);
    end
    check("t1_done_count", done_cnt, 32'd1);
    check("t1_busy_done", {31'b0, busy}, 32'h0);
    check("t1_error", {31'b0, error}, 32'h0);
    check("t1_addr_hold", address, 32'h1C);
    send_byte(8'h55);
    idle(1);
    check("t1_extra_ignored", wr_addr.size(), 32'd8);
    close_window();

    // 2. Zero-length load
    clear_log();
    open_window();
    send_byte(8'h00);
    check("t2_done_pulse", {31'b0, load_done}, 32'h1);
    check("t2_inst_count", {24'b0, inst_count}, 32'h0);
    idle(3);
    check("t2_num_writes", wr_addr.size(), 32'd0);
    check("t2_done_count", done_cnt, 32'd1);
    close_window();

    // 3. Abort after five bytes of a two-word load
    clear_log();
    open_window();
    send_byte(8'd2);
    send_word(32'hCAFEF00D);
    send_byte(8'h77);
    load_en = 1'b0;
    idle(3);
    check("t3_num_writes", wr_addr.size(), 32'd1);
    if (wr_addr.size() > 0) check("t3_addr0", wr_addr[0], 32'h0);
    check("t3_error", {31'b0, error}, 32'h1);
    check("t3_busy_idle", {31'b0, busy}, 32'h0);
    check("t3_no_done", done_cnt, 32'd0);
    open_window();
    check("t3_error_cleared", {31'b0, error}, 32'h0);
    check("t3_address_cleared", address, 32'h0);
    close_window();

    // 4. Count plus 12 bytes strobed every cycle
    clear_log();
    open_window();
    send_byte(8'd3);
    for (int i = 0; i < 3; i++) send_word(prog4[i]);
`ifdef DU_LOADER_CHECKSUM_EN
    send_byte(csum);
`endif
    idle(2);
    check("t4_num_writes", wr_addr.size(), 32'd3);
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      check($sformatf("t4_addr%0d", i), wr_addr[i], 32'(i * 4));
      check($sformatf("t4_data%0d", i), wr_data[i], prog4[i]);
    end
    if (wr_cyc.size() == 3) begin
      check("t4_gap01", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
      check("t4_gap12", 32'(wr_cyc[2] - wr_cyc[1]), 32'd4);
    end
    check("t4_done_count", done_cnt, 32'd1);
    close_window();

    // 5. Reset arrives together with the last byte of word 0
    clear_log();
    open_window();
    send_byte(8'd1);
    send_byte(8'h44);
    send_byte(8'h33);
    send_byte(8'h22);
    rx_data = 8'h11;
    rx_done = 1'b1;
    rst     = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    idle(1);
    check("t5_no_write", wr_addr.size(), 32'd0);
    check("t5_en_write", {31'b0, en_write}, 32'h0);
    check("t5_address", address, 32'h0);
    check("t5_inst_load", inst_load, 32'h0);
    check("t5_busy", {31'b0, busy}, 32'h0);
    check("t5_inst_count", {24'b0, inst_count}, 32'h0);
    check("t5_error", {31'b0, error}, 32'h0);
    rst = 1'b0;
    close_window();

`ifdef DU_LOADER_CHECKSUM_EN
    // 6a. Correct checksum
    clear_log();
    open_window();
    send_byte(8'd1);
    send_word(32'hAABBCCDD);
    send_byte(8'h01);
    idle(2);
    check("t6_num_writes", wr_addr.size(), 32'd1);
    check("t6_done_count", done_cnt, 32'd1);
    check("t6_error", {31'b0, error}, 32'h0);
    close_window();

    // 6b. Wrong checksum
    clear_log();
    open_window();
    send_byte(8'd1);
    send_word(32'hAABBCCDD);
    send_byte(8'h02);
    idle(2);
    check("t6b_num_writes", wr_addr.size(), 32'd1);
    check("t6b_no_done", done_cnt, 32'd0);
    check("t6b_error", {31'b0, error}, 32'h1);
    close_window();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
